// File: rtl/gcttt_pkg.sv
// Shared types and constants for the IPU interrupt sequencer.
package gcttt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ASSERT = 2'd2,
    GAP    = 2'd3
  } state_t;

  typedef logic [3:0] coord_t;

  localparam coord_t NO_COORD       = 4'hF;
  localparam int     GRID_CELLS_DEF = 9;

  function automatic logic coord_legal(input coord_t c, input int cells);
    return int'(c) < cells;
  endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO with first-word fall-through head and an occupancy counter.
module coord_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define
  // which entries are live, and leaving the array reset-free keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ipu_int_ctrl.sv
// IPU coordinate filter, burst FIFO and ipu_int/int_ack handshake sequencer.
// Optional build macro: OCCUPIED_FILTER_EN (drops coordinates already delivered or queued).
module ipu_int_ctrl
  import gcttt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int GRID_CELLS = GRID_CELLS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coord_valid,
  input  logic [3:0]                  coord_in,
  input  logic                        int_ack,
  input  logic                        game_clr,
  output logic                        ipu_int,
  output logic [3:0]                  grid_coord,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic                        overflow,
  output logic                        bad_coord
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;

  coord_t fifo_head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;
  logic   in_range;
  logic   dup;

  assign in_range = coord_legal(coord_in, GRID_CELLS);

`ifdef OCCUPIED_FILTER_EN
  logic [GRID_CELLS-1:0] occupied;
  logic [GRID_CELLS-1:0] queued;

  // Duplicates never enter the FIFO, so a per-cell bit tracks its contents exactly.
  assign dup = in_range && (occupied[coord_in] || queued[coord_in]);

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= '0;
      queued   <= '0;
    end else begin
      if (game_clr) occupied <= '0;
      if (fifo_pop) begin
        occupied[fifo_head] <= 1'b1;
        queued[fifo_head]   <= 1'b0;
      end
      if (fifo_push) queued[coord_in] <= 1'b1;
    end
  end
`else
  logic unused_game_clr;

  assign dup             = 1'b0;
  assign unused_game_clr = game_clr;
`endif

  // A pop in the same cycle never frees room for a push: full is pre-edge.
  assign fifo_push = coord_valid && in_range && !dup && !fifo_full;
  assign fifo_pop  = (state == LOAD);

  coord_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(coord_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (coord_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      bad_coord <= 1'b0;
    end else begin
      if (coord_valid && !in_range)                 bad_coord <= 1'b1;
      if (coord_valid && in_range && !dup && fifo_full) overflow  <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ipu_int    <= 1'b0;
      grid_coord <= NO_COORD;
      gap_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          grid_coord <= fifo_head;
          ipu_int    <= 1'b1;
          state      <= ASSERT;
        end
        ASSERT: begin
          if (int_ack) begin
            ipu_int <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ipu_int_ctrl.md
Name: ipu_int_ctrl

Overview:
Sequences coordinate events from the input processing unit (IPU) into the processor's interrupt interface. Filters out-of-range cells and buffers bursts in a small FIFO. Drives the held grid-coordinate register and runs the ipu_int/int_ack handshake. Sits between the IPU/touch front-end and proc; it replaces the free-standing grid_coord register plus ad-hoc interrupt glue.

Parameters:
FIFO_DEPTH, 4, coordinate queue depth; power of two, minimum 2.
GAP_CYCLES, 2, minimum ipu_int low cycles after an ack before the next assertion; minimum 1.
GRID_CELLS, 9, number of valid cells; a coordinate is legal only if it is below this value.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
coord_valid  in  1  single-cycle pulse: coord_in is a new event.
coord_in  in  4  cell index from the IPU.
int_ack  in  1  proc acknowledges the current interrupt.
game_clr  in  1  new-game pulse; used only with the optional feature.
ipu_int  out  1  interrupt to proc, registered.
grid_coord  out  4  coordinate presented to proc, registered.
pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
bad_coord  out  1  sticky: an event was dropped because it was out of range.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - ipu_int=0, grid_coord=4'hF (NO_COORD), pending=0, overflow=0, bad_coord=0.
  - FIFO is emptied, state=IDLE, gap counter=0.
  - Reset applied mid-handshake abandons the event; no ack is expected afterwards.
- Input acceptance (every cycle, independent of state):
  - coord_valid && coord_in>=GRID_CELLS: drop the event; set bad_coord.
  - coord_valid, in range, FIFO full: drop the event; set overflow. A same-cycle pop does NOT make room.
  - Otherwise a valid in-range event is pushed at that edge.
- Sticky flags clear only on rst.
- FSM states: IDLE, LOAD, ASSERT, GAP.
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: pop the FIFO head into grid_coord; -> ASSERT. ipu_int is set at the same edge.
  - ASSERT: ipu_int held 1, grid_coord stable. On int_ack: ipu_int->0, gap counter loads GAP_CYCLES-1, -> GAP.
  - GAP: ipu_int=0; when the counter reaches 0 -> IDLE, else decrement.
- grid_coord holds the last delivered value until the next LOAD. It never returns to NO_COORD except on reset.
- Latency: push at edge E with the FSM in IDLE and the FIFO empty gives state LOAD after E+1, and ipu_int=1 with the new grid_coord after E+2.
- Minimum spacing from one ack edge to the next ipu_int rise is GAP_CYCLES+2 cycles.
- int_ack outside ASSERT is ignored.
- int_ack in the same cycle as the rise is impossible, because ipu_int is registered and the ack is sampled only in ASSERT.
- Simultaneous push and pop: both occur and pending is unchanged.
- Pointers wrap modulo FIFO_DEPTH. pending is a separate up/down counter, range 0..FIFO_DEPTH.
- game_clr has no effect without the optional feature.

Optional Feature:
Macro OCCUPIED_FILTER_EN.
- Defined:
  - A GRID_CELLS-bit occupied mask is set for each coordinate at LOAD.
  - An in-range coord_valid whose cell bit is set, or which matches any FIFO entry, is dropped silently: no flag, no push.
  - game_clr clears the mask next edge and does not affect the FIFO or the FSM.
  - rst clears the mask.
- Undefined: no mask exists; duplicates are queued and delivered normally; game_clr is ignored.

Decomposition:
- Package gcttt_pkg holds:
  - the state typedef (IDLE/LOAD/ASSERT/GAP);
  - NO_COORD=4'hF;
  - GRID_CELLS_DEF=9;
  - the coord_t 4-bit typedef.
- One sub-module, coord_fifo: synchronous FIFO parameterised by DEPTH and width, with push, pop, full, empty and count. The FSM, filters and flags stay in ipu_int_ctrl.

Test Plan:
- Single event: rst released, coord_valid with coord_in=4 at edge E -> ipu_int=1 and grid_coord=4 after E+2; int_ack one cycle -> ipu_int=0 next edge; pending=0.
- Burst: 3 back-to-back events 1, 5, 8, acking each after 3 cycles -> delivered in order 1, 5, 8. Each rise is at least GAP_CYCLES+2 cycles after the previous ack; pending peaks at 2.
- Overflow: 6 consecutive events 0..5 with no ack -> 0 delivered, 1..4 queued, event 5 dropped; pending=4 and overflow=1, sticky until rst.
- Range: coord_in=9 and coord_in=15 pulses -> no push, bad_coord=1, ipu_int stays 0.
- Reset mid-handshake: rst during ASSERT with 2 queued -> next cycle ipu_int=0, grid_coord=4'hF, pending=0, flags=0.
- OCCUPIED_FILTER_EN: deliver 3, then submit 3 again -> dropped with no flag. After a game_clr pulse, 3 is accepted and delivered.
